// File: rtl/obi_pkg.sv
// Shared relOBI types for the replicated R-channel synchronizer: bus configuration,
// the synchronizer FSM states and the drop-counter width helper.
package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

  typedef enum logic {
    ALIGN,
    DEGRADED
  } relobi_sync_state_e;

  // Headroom of two bits over the FIFO depth so stale beats of several degraded votes queue up.
  function automatic int unsigned relobi_drop_cnt_width(input int unsigned depth);
    return $clog2(depth) + 2;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small circular-buffer FIFO with optional fall-through and an async active-low reset.
// Memory is reset as well so the read port shows zero after reset.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0]
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  dtype            mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            wr_en, rd_en, bypass;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i;
  assign empty_o = (cnt_q == '0) & ~bypass;
  assign data_o  = bypass ? data_i : mem_q[rd_ptr_q];
  // A bypassed beat popped in the same cycle never lands in memory.
  assign wr_en   = push_i & ~full_o & ~(bypass & pop_i);
  assign rd_en   = pop_i & ~empty_o & ~bypass;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (rd_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CntW'(wr_en) - CntW'(rd_en);
    end
  end

endmodule

// File: rtl/relobi_tmr_r_sync.sv
// Aligns three replica R streams through per-replica FIFOs and emits one majority-voted beat.
// A replica absent for SkewTimeout cycles is skipped once and its stale beat discarded later.
module relobi_tmr_r_sync
  import obi_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg       = ObiDefaultConfig,
  parameter type         obi_r_chan_t = logic,
  parameter int unsigned Depth        = 2,
  parameter int unsigned SkewTimeout  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  obi_r_chan_t [2:0] three_r_i,
  input  logic        [2:0] three_rvalid_i,
  output logic        [2:0] three_rready_o,
  output obi_r_chan_t       voted_r_o,
  output logic              voted_rvalid_o,
  input  logic              voted_rready_i,
  output logic              mismatch_o,
  output logic              timeout_o,
  output logic        [2:0] replica_fault_o
);
  localparam int unsigned DropW = relobi_drop_cnt_width(Depth);
  localparam int unsigned SkewW = $clog2(SkewTimeout + 1);
  localparam int unsigned W     = $bits(obi_r_chan_t);

  if (Depth < 1) begin : gen_bad_depth
    $error("Depth must be >= 1");
  end
  if (SkewTimeout < 1) begin : gen_bad_timeout
    $error("SkewTimeout must be >= 1");
  end
  if (ObiCfg.DataWidth == 0) begin : gen_bad_cfg
    $error("ObiCfg.DataWidth must be non-zero");
  end

  obi_r_chan_t [2:0]    head;
  logic [2:0]           full, empty, valid, push, pop, drop_inc, drop_dec, fault_set;
  logic [DropW-1:0]     drop_cnt_q [3];
  relobi_sync_state_e   state_q;
  logic [SkewW-1:0]     skew_q;
  logic [2:0]           mask_q, fault_q;
  logic                 timeout_q, two_valid, handshake, heads_differ;
  logic [W-1:0]         maj;

  for (genvar i = 0; i < 3; i++) begin : gen_replica
    logic drop_pending, accept;

    fifo_v3 #(
      .FALL_THROUGH (1'b0),
      .DEPTH        (Depth),
      .dtype        (obi_r_chan_t)
    ) i_fifo (
      .clk_i   (clk_i),
      .rst_ni  (~rst_i),
      .flush_i (1'b0),
      .full_o  (full[i]),
      .empty_o (empty[i]),
      .data_i  (three_r_i[i]),
      .push_i  (push[i]),
      .data_o  (head[i]),
      .pop_i   (pop[i])
    );

    assign drop_pending      = (drop_cnt_q[i] != '0);
    assign three_rready_o[i] = ~rst_i & (drop_pending | ~full[i]);
    assign accept            = three_rvalid_i[i] & three_rready_o[i];
    assign push[i]           = accept & ~drop_pending;
    assign drop_dec[i]       = accept & drop_pending;
    assign valid[i]          = ~empty[i];
  end

  assign maj       = (head[0] & head[1]) | (head[0] & head[2]) | (head[1] & head[2]);
  assign two_valid = (valid == 3'b011) | (valid == 3'b101) | (valid == 3'b110);

  always_comb begin
    voted_rvalid_o = 1'b0;
    voted_r_o      = obi_r_chan_t'(maj);
    heads_differ   = (head[0] != head[1]) | (head[1] != head[2]);
    pop            = '0;
    drop_inc       = '0;
    fault_set      = '0;
    if (state_q == DEGRADED) begin
      // Mask is frozen, so the presented beat cannot change while the manager stalls.
      voted_rvalid_o = 1'b1;
      voted_r_o      = mask_q[0] ? head[0] : head[1];
      heads_differ   = mask_q[0] ? (head[0] != (mask_q[1] ? head[1] : head[2]))
                                 : (head[1] != head[2]);
    end else if (valid == 3'b111) begin
      voted_rvalid_o = 1'b1;
    end
    handshake = voted_rvalid_o & voted_rready_i;
    if (handshake) begin
      if (state_q == DEGRADED) begin
        pop       = mask_q | valid;
        drop_inc  = ~mask_q & ~valid;
        fault_set = ~mask_q;
      end else begin
        pop = 3'b111;
      end
    end
  end

  assign mismatch_o      = handshake & heads_differ;
  assign timeout_o       = timeout_q;
  assign replica_fault_o = fault_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ALIGN;
      skew_q    <= '0;
      mask_q    <= '0;
      fault_q   <= '0;
      timeout_q <= 1'b0;
      for (int i = 0; i < 3; i++) drop_cnt_q[i] <= '0;
    end else begin
      timeout_q <= 1'b0;
      fault_q   <= fault_q | fault_set;
      case (state_q)
        ALIGN: begin
          if (!two_valid) begin
            skew_q <= '0;
          end else if (skew_q == SkewW'(SkewTimeout - 1)) begin
            skew_q    <= SkewW'(SkewTimeout);
            timeout_q <= 1'b1;
            mask_q    <= valid;
            state_q   <= DEGRADED;
          end else begin
            skew_q <= skew_q + 1'b1;
          end
        end
        DEGRADED: begin
          if (handshake) begin
            state_q <= ALIGN;
            skew_q  <= '0;
          end
        end
        default: state_q <= ALIGN;
      endcase
      // Saturation only happens on a degraded handshake, which already flags the replica.
      for (int i = 0; i < 3; i++) begin
        if (drop_inc[i] && !drop_dec[i]) begin
          if (drop_cnt_q[i] != '1) drop_cnt_q[i] <= drop_cnt_q[i] + 1'b1;
        end else if (drop_dec[i] && !drop_inc[i]) begin
          drop_cnt_q[i] <= drop_cnt_q[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_relobi_tmr_r_sync.sv
// Directed bench for relobi_tmr_r_sync: per-cycle vector table plus reset and backpressure
// sequences. Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_relobi_tmr_r_sync;

  typedef struct packed {
    logic [31:0] rdata;
    logic [6:0]  rdata_ecc;
    logic [3:0]  rid;
    logic        err;
    logic        r_optional;
    logic [5:0]  other_ecc;
  } r_t;

  typedef struct {
    logic [2:0]  v;
    logic [31:0] d0, d1, d2;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic        em, eto;
    logic [2:0]  err, ef;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  r_t   [2:0] three_r = '0;
  logic [2:0] three_rvalid = '0;
  logic [2:0] three_rready;
  r_t         voted_r;
  logic       voted_rvalid;
  logic       voted_rready = 1'b0;
  logic       mismatch, timeout;
  logic [2:0] replica_fault;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  relobi_tmr_r_sync #(
    .obi_r_chan_t (r_t),
    .Depth        (2),
    .SkewTimeout  (8)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .three_r_i       (three_r),
    .three_rvalid_i  (three_rvalid),
    .three_rready_o  (three_rready),
    .voted_r_o       (voted_r),
    .voted_rvalid_o  (voted_rvalid),
    .voted_rready_i  (voted_rready),
    .mismatch_o      (mismatch),
    .timeout_o       (timeout),
    .replica_fault_o (replica_fault)
  );

  function automatic r_t mk(input logic [31:0] d);
    r_t r;
    r.rdata      = d;
    r.rdata_ecc  = d[6:0];
    r.rid        = d[3:0];
    r.err        = d[0];
    r.r_optional = d[1];
    r.other_ecc  = d[5:0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic rdy);
    @(negedge clk);
    three_r[0]   = mk(d0);
    three_r[1]   = mk(d1);
    three_r[2]   = mk(d2);
    three_rvalid = v;
    voted_rready = rdy;
    #1;
  endtask

  function automatic void add(input logic [2:0] v, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic ev, input logic [31:0] ed,
                              input logic em, input logic eto, input logic [2:0] ef);
    vec_t e;
    e.v = v; e.d0 = d0; e.d1 = d1; e.d2 = d2; e.rdy = 1'b1;
    e.ev = ev; e.ed = ed; e.em = em; e.eto = eto; e.err = 3'b111; e.ef = ef;
    tbl.push_back(e);
  endfunction

  logic [31:0] exp_q[$];
  int          sent, got;
  logic        rdy_bp;
  logic [2:0]  v_bp;
  logic [31:0] d_bp;

  initial begin
    // Identical triple, then a single-bit upset on replica 1.
    add(3'b111, 32'h1234, 32'h1234, 32'h1234, 0, 0, 0, 0, 3'b000);
    add(3'b000, 0, 0, 0,                      1, 32'h1234, 0, 0, 3'b000);
    add(3'b000, 0, 0, 0,                      0, 0, 0, 0, 3'b000);
    add(3'b111, 32'h1234, 32'h1235, 32'h1234, 0, 0, 0, 0, 3'b000);
    add(3'b000, 0, 0, 0,                      1, 32'h1234, 1, 0, 3'b000);
    add(3'b000, 0, 0, 0,                      0, 0, 0, 0, 3'b000);
    // Replica 2 three cycles late: within the skew bound.
    add(3'b011, 32'ha0a0, 32'ha0a0, 0,        0, 0, 0, 0, 3'b000);
    add(3'b000, 0, 0, 0,                      0, 0, 0, 0, 3'b000);
    add(3'b000, 0, 0, 0,                      0, 0, 0, 0, 3'b000);
    add(3'b100, 0, 0, 32'ha0a0,               0, 0, 0, 0, 3'b000);
    add(3'b000, 0, 0, 0,                      1, 32'ha0a0, 0, 0, 3'b000);
    add(3'b000, 0, 0, 0,                      0, 0, 0, 0, 3'b000);
    // Replica 2 silent: heads 0/1 valid for 8 cycles, then a degraded beat.
    add(3'b011, 32'h5555, 32'h5555, 0,        0, 0, 0, 0, 3'b000);
    for (int i = 0; i < 8; i++) add(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    add(3'b000, 0, 0, 0,                      1, 32'h5555, 0, 1, 3'b000);
    add(3'b000, 0, 0, 0,                      0, 0, 0, 0, 3'b100);
    // Stale beat from replica 2 is swallowed; the next triple still aligns.
    add(3'b100, 0, 0, 32'h5555,               0, 0, 0, 0, 3'b100);
    add(3'b000, 0, 0, 0,                      0, 0, 0, 0, 3'b100);
    add(3'b111, 32'h7777, 32'h7777, 32'h7777, 0, 0, 0, 0, 3'b100);
    add(3'b000, 0, 0, 0,                      1, 32'h7777, 0, 0, 3'b100);
    add(3'b000, 0, 0, 0,                      0, 0, 0, 0, 3'b100);

    // Reset state.
    drive(3'b000, 0, 0, 0, 1'b1);
    chk("reset rvalid", 64'(voted_rvalid), 64'(1'b0));
    chk("reset rready", 64'(three_rready), 64'(3'b000));
    chk("reset fault", 64'(replica_fault), 64'(3'b000));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].rdy);
      chk($sformatf("row%0d rvalid", i), 64'(voted_rvalid), 64'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("row%0d voted_r", i), 64'(voted_r), 64'(mk(tbl[i].ed)));
      chk($sformatf("row%0d mismatch", i), 64'(mismatch), 64'(tbl[i].em));
      chk($sformatf("row%0d timeout", i), 64'(timeout), 64'(tbl[i].eto));
      chk($sformatf("row%0d rready", i), 64'(three_rready), 64'(tbl[i].err));
      chk($sformatf("row%0d fault", i), 64'(replica_fault), 64'(tbl[i].ef));
    end

    // Reset with buffered beats and a pending voted beat.
    drive(3'b111, 32'h1111, 32'h1111, 32'h1111, 1'b0);
    drive(3'b111, 32'h2222, 32'h2222, 32'h2222, 1'b0);
    chk("pre-reset rvalid", 64'(voted_rvalid), 64'(1'b1));
    chk("pre-reset data", 64'(voted_r), 64'(mk(32'h1111)));
    @(negedge clk);
    three_rvalid = 3'b000;
    rst          = 1'b1;
    #1;
    chk("mid reset rvalid", 64'(voted_rvalid), 64'(1'b0));
    chk("mid reset rready", 64'(three_rready), 64'(3'b000));
    chk("mid reset voted_r", 64'(voted_r), 64'(0));
    chk("mid reset fault", 64'(replica_fault), 64'(3'b000));
    chk("mid reset pulses", 64'({mismatch, timeout}), 64'(2'b00));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(3'b000, 0, 0, 0, 1'b1);
      chk("post reset idle", 64'(voted_rvalid), 64'(1'b0));
    end
    drive(3'b111, 32'h3333, 32'h3333, 32'h3333, 1'b1);
    drive(3'b000, 0, 0, 0, 1'b1);
    chk("post reset rvalid", 64'(voted_rvalid), 64'(1'b1));
    chk("post reset data", 64'(voted_r), 64'(mk(32'h3333)));
    chk("post reset mismatch", 64'(mismatch), 64'(1'b0));

    // Backpressure: manager stalls 5 cycles while replicas stream six beats.
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      rdy_bp = (c >= 5);
      v_bp   = (sent < 6) ? 3'b111 : 3'b000;
      d_bp   = 32'h100 + 32'(sent) + 1;
      drive(v_bp, d_bp, d_bp, d_bp, rdy_bp);
      if (c >= 2 && c <= 4) chk("bp rready full", 64'(three_rready), 64'(3'b000));
      if (c >= 1 && c <= 4) begin
        chk("bp hold rvalid", 64'(voted_rvalid), 64'(1'b1));
        chk("bp hold data", 64'(voted_r), 64'(mk(32'h101)));
      end
      if (voted_rvalid && rdy_bp) begin
        if (exp_q.size() == 0) chk("bp extra beat", 64'(voted_r.rdata), 64'hffff_ffff_ffff_ffff);
        else chk("bp order", 64'(voted_r), 64'(mk(exp_q.pop_front())));
        got++;
      end
      if (v_bp != 3'b000 && three_rready == 3'b111) begin
        exp_q.push_back(d_bp);
        sent++;
      end else if (v_bp != 3'b000 && three_rready != 3'b000) begin
        chk("bp rready uniform", 64'(three_rready), 64'(3'b000));
      end
    end
    chk("bp beats sent", 64'(sent), 64'(6));
    chk("bp beats delivered", 64'(got), 64'(6));
    chk("bp nothing left", 64'(exp_q.size()), 64'(0));
    drive(3'b000, 0, 0, 0, 1'b1);
    chk("bp drained", 64'(voted_rvalid), 64'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
